// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead
// slice, one nibble per clock (LSB first), with a start/done handshake.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_shift;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic [3:0] slice_sum;
  logic       slice_cout;
  logic       last_slice;

  // Shared carry-lookahead slice working on the low nibble of the shifting operands.
  assign g = op_a[3:0] & op_b[3:0];
  assign p = op_a[3:0] ^ op_b[3:0];

  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & carry);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & carry);
  assign slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                      (p[3] & p[2] & p[1] & g[0]) |
                      (p[3] & p[2] & p[1] & p[0] & carry);
  assign slice_sum = p ^ c;

  assign last_slice = (idx == LAST_IDX);

  // The slice result enters the top nibble, so after NSLICE shifts the accumulator is aligned.
  generate
    if (WIDTH == 4) begin : g_single
      assign acc_shift = slice_sum;
    end else begin : g_multi
      assign acc_shift = {slice_sum, acc[WIDTH-1:4]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1: invert B once at acceptance and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_shift;
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          carry <= slice_cout;
          idx   <= idx + IDXW'(1);
          // On the top nibble op_a[3]/op_b[3] are the effective operand sign bits.
          if (last_slice) begin
            sum_r  <= acc_shift;
            cout_r <= slice_cout;
            ovf_r  <= (op_a[3] == op_b[3]) && (slice_sum[3] != op_a[3]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule
